// File: rtl/book_ram_arbiter.sv
// Round-robin arbiter sharing the buy/sell order RAMs between book engines, with grant lock and lock watchdog.
// Optional macro ARB_PRIORITY_EN: requester 0 (order entry) wins every arbitration and pre-empts locked owners.
module book_ram_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 48,
    parameter int RD_LAT   = 2,
    parameter int LOCK_MAX = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        side,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         buy_addr,
    output logic [ADDR_W-1:0]         sell_addr,
    output logic [DATA_W-1:0]         buy_wdata,
    output logic [DATA_W-1:0]         sell_wdata,
    output logic                      buy_we,
    output logic                      sell_we,
    input  logic [DATA_W-1:0]         buy_rdata,
    input  logic [DATA_W-1:0]         sell_rdata,
    output logic                      rd_valid,
    output logic [2:0]                rd_id,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      lock_timeout
);

    localparam int IDX_W = 3;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, OWN, LOCKED} state_t;

    state_t                       state, state_next;
    logic [IDX_W-1:0]             owner, owner_next;
    logic [IDX_W-1:0]             ptr, ptr_next;
    logic [CNT_W-1:0]             lock_cnt, lock_cnt_next;
    logic                         timeout_next;
    logic                         do_rel;
    logic [IDX_W:0]               rel_pick;
    logic [IDX_W:0]               pick_idle, pick_own, pick_ex;
    logic [NUM_REQ-1:0]           own_mask;
    logic                         own_req, own_lock, own_we, own_side;
    logic [ADDR_W-1:0]            own_addr;
    logic [DATA_W-1:0]            own_wdata;
    logic                         access, buy_sel, sell_sel;
    logic [ADDR_W-1:0]            buy_addr_q, sell_addr_q;
    logic [DATA_W-1:0]            buy_wdata_q, sell_wdata_q;
    logic [RD_LAT-1:0]            pipe_valid, pipe_side;
    logic [RD_LAT-1:0][IDX_W-1:0] pipe_id;

    // Returns {found, index}: first set bit of mask searching upward from from+1, wrapping; from itself is last.
    function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] mask, input logic [IDX_W-1:0] from);
        logic [IDX_W:0] res;
        int             best_d;
        int             d;
        res    = '0;
        best_d = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i + 2 * NUM_REQ - int'(from) - 1) % NUM_REQ;
            if (mask[i] && (d < best_d)) begin
                best_d = d;
                res    = {1'b1, IDX_W'(i)};
            end
        end
`ifdef ARB_PRIORITY_EN
        if (mask[0]) begin
            res = {1'b1, {IDX_W{1'b0}}};
        end
`endif
        return res;
    endfunction

    always_comb begin
        own_mask  = '0;
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_we    = 1'b0;
        own_side  = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                own_mask[i] = 1'b1;
                own_req     = req[i];
                own_lock    = lock[i];
                own_we      = we[i];
                own_side    = side[i];
                own_addr    = addr[i*ADDR_W +: ADDR_W];
                own_wdata   = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign access    = (state != IDLE) && own_req;
    assign gnt       = (state != IDLE) ? own_mask : '0;
    assign pick_idle = pick(req, ptr);
    assign pick_own  = pick(req, owner);
    assign pick_ex   = pick(req & ~own_mask, owner);

    always_comb begin
        state_next    = state;
        owner_next    = owner;
        ptr_next      = ptr;
        lock_cnt_next = lock_cnt;
        timeout_next  = 1'b0;
        do_rel        = 1'b0;
        rel_pick      = pick_own;
        unique case (state)
            IDLE: begin
                if (pick_idle[IDX_W]) begin
                    state_next = OWN;
                    owner_next = pick_idle[IDX_W-1:0];
                end
            end
            OWN: begin
                if (access && own_lock) begin
                    state_next    = LOCKED;
                    lock_cnt_next = CNT_W'(1);
                end else begin
                    do_rel = 1'b1;
                end
            end
            LOCKED: begin
                if (!access || !own_lock) begin
                    do_rel = 1'b1;
`ifdef ARB_PRIORITY_EN
                end else if (req[0] && (owner != '0)) begin
                    do_rel       = 1'b1;
                    rel_pick     = pick_ex;
                    timeout_next = 1'b1;
`endif
                end else if (lock_cnt >= CNT_W'(LOCK_MAX)) begin
                    // Watchdog: release only if someone else is waiting, otherwise saturate and keep the grant.
                    if (pick_ex[IDX_W]) begin
                        do_rel       = 1'b1;
                        rel_pick     = pick_ex;
                        timeout_next = 1'b1;
                    end
                end else begin
                    lock_cnt_next = lock_cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (do_rel) begin
            ptr_next      = owner;
            lock_cnt_next = '0;
            if (rel_pick[IDX_W]) begin
                state_next = OWN;
                owner_next = rel_pick[IDX_W-1:0];
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= '0;
            ptr          <= IDX_W'(NUM_REQ - 1);
            lock_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            state        <= state_next;
            owner        <= owner_next;
            ptr          <= ptr_next;
            lock_cnt     <= lock_cnt_next;
            lock_timeout <= timeout_next;
        end
    end

    // The RAM not selected this cycle keeps its previous address and data with we low.
    assign buy_sel    = access && !own_side;
    assign sell_sel   = access && own_side;
    assign buy_addr   = buy_sel ? own_addr : buy_addr_q;
    assign sell_addr  = sell_sel ? own_addr : sell_addr_q;
    assign buy_wdata  = buy_sel ? own_wdata : buy_wdata_q;
    assign sell_wdata = sell_sel ? own_wdata : sell_wdata_q;
    assign buy_we     = buy_sel && own_we;
    assign sell_we    = sell_sel && own_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buy_addr_q   <= '0;
            sell_addr_q  <= '0;
            buy_wdata_q  <= '0;
            sell_wdata_q <= '0;
        end else begin
            if (buy_sel) begin
                buy_addr_q  <= own_addr;
                buy_wdata_q <= own_wdata;
            end
            if (sell_sel) begin
                sell_addr_q  <= own_addr;
                sell_wdata_q <= own_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= '0;
            pipe_side  <= '0;
            pipe_id    <= '0;
        end else begin
            pipe_valid[0] <= access && !own_we;
            pipe_side[0]  <= own_side;
            pipe_id[0]    <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_side[i]  <= pipe_side[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    assign rd_valid = pipe_valid[RD_LAT-1];
    assign rd_id    = pipe_id[RD_LAT-1];
    assign rd_data  = !rd_valid ? '0 : (pipe_side[RD_LAT-1] ? sell_rdata : buy_rdata);

endmodule

// File: doc/book_ram_arbiter.md
Name: book_ram_arbiter

Overview:
Shares the buy-side and sell-side order RAMs between several book engines, such as the volume-at-limit query, best-price scan and order entry/cancel writer. Arbitration is round-robin, with an optional lock that holds the grant for a burst scan. A lock watchdog prevents starvation. Read data is returned with the requester ID after a fixed RAM latency. Sits between the book engines and the two RAM macros.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 12, order RAM address width
DATA_W, 48, order word width ([15:0] price, [31:16] volume, [47:32] order id)
RD_LAT, 2, cycles from access cycle to rd_valid (RAM address and output registers)
LOCK_MAX, 64, maximum consecutive locked grant cycles before forced release

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester access request
lock  in  NUM_REQ  per-requester request to keep grant after this cycle
side  in  NUM_REQ  per-requester RAM select: 0 buy, 1 sell
we  in  NUM_REQ  per-requester write enable
addr  in  NUM_REQ*ADDR_W  per-requester address, requester k at [k*ADDR_W +: ADDR_W]
wdata  in  NUM_REQ*DATA_W  per-requester write data, same packing
gnt  out  NUM_REQ  one-hot registered grant
buy_addr, sell_addr  out  ADDR_W  RAM addresses
buy_wdata, sell_wdata  out  DATA_W  RAM write data
buy_we, sell_we  out  1  RAM write enables
buy_rdata, sell_rdata  in  DATA_W  RAM read data
rd_valid  out  1  read data valid pulse
rd_id  out  3  requester index for rd_data
rd_data  out  DATA_W  returned word
lock_timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst=0, asynchronous) values:
  - gnt=0, rd_valid=0, rd_id=0, rd_data=0, lock_timeout=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Lock counter = 0; read pipeline fully cleared.
  - Reset mid-burst discards all in-flight reads: no rd_valid after reset release until a new read is issued.
- States:
  - IDLE: gnt=0. Next edge: if any req, grant the first requester with req=1 searching from pointer+1 (wrapping) -> OWN.
  - OWN: gnt[k]=1.
    - Access cycle = gnt[k] & req[k].
    - At the edge ending an access cycle with lock[k]=1 -> LOCKED, counter=1.
    - Otherwise re-arbitrate with pointer=k: pick another requester -> OWN, or none -> IDLE.
    - If req[k]=0 the cycle is not an access and lock is ignored.
  - LOCKED: gnt[k] held.
    - Each access cycle with lock[k]=1 increments the counter.
    - If lock[k]=0 or req[k]=0, re-arbitrate as in OWN.
    - When the counter reaches LOCK_MAX and another req is pending: forced re-arbitration excluding k, lock_timeout=1 for one cycle, counter=0.
    - If no other req is pending, the counter saturates and the grant is kept.
- Access cycle routing:
  - The owner's addr/wdata drive the RAM selected by side[k]; the other RAM's address holds its last value with we=0.
  - buy_we = we[k] & ~side[k]; sell_we = we[k] & side[k]. The write completes in the access cycle.
- Reads (we[k]=0):
  - Issued in the access cycle; {valid, side, id} are shifted through an RD_LAT-deep pipeline.
  - rd_valid is asserted exactly RD_LAT cycles later; rd_data is muxed from buy_rdata/sell_rdata by the pipelined side; rd_id = k.
  - Back-to-back reads give one rd_valid per cycle, in order.
  - Writes produce no rd_valid.
- Minimum throughput: one access per cycle while the owner holds the grant. A grant handoff costs zero idle cycles when another req is pending.
- Read-after-write: same side and address in consecutive access cycles returns the new data. This relies on the RAM being configured with new-data read-during-write; the arbiter adds no bypass.
- The arbiter does not check addresses or lock/we combinations: lock with we is legal, and addresses above book size are the requester's responsibility.

Optional Feature:
ARB_PRIORITY_EN:
- Defined: requester 0 (order entry) wins every arbitration point when req[0]=1, regardless of the pointer. It also pre-empts a LOCKED owner at the lock-watchdog boundary even before LOCK_MAX: the locked owner loses the grant at the next edge after req[0] rises, and lock_timeout pulses.
- Undefined: pure round-robin as above.

Test Plan:
1. Reset, then req=3'b001, we=0, side=0, addr=5, buy_rdata model returns {16'd7,16'd100,16'd250} -> gnt=001 the cycle after req; rd_valid at access+2, rd_id=0, rd_data price 250, volume 100.
2. req=3'b111 held, no lock -> gnt sequence 001,010,100,001 on consecutive cycles; no idle cycles.
3. Requester 1 lock=1 for 10 reads of sell addrs 0..9 while req[2]=1 -> gnt stays 010 for 10 access cycles; rd_id=1 for all 10 rd_valid, in order; gnt moves to 100 after lock drops.
4. LOCK_MAX=4, requester 2 holds lock with req[0]=1 pending -> after 4 locked cycles lock_timeout pulses once, gnt=001.
5. Requester 0 writes buy addr 3 with price 300, then reads addr 3 next cycle -> buy_we=1 for one cycle, sell_we=0; read returns price 300.
6. rst low while two reads are in flight -> rd_valid stays 0 after release; gnt=0; the next grant goes to requester 0 first.
